// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// Holds the FSM state encoding and the bit-counter width rule.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // A one-bit counter still needs a storage bit, so clamp at 1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// One-bit combinational full adder.
// The serial datapath reuses this single cell for every bit position.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full-adder cell processes LSB first over WIDTH cycles.
// Results, carry-out and signed overflow are held until the next completion.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, busy_q, done_q;
  logic             s_w, co_w;
  logic             accept;

  fa_cell u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (c_q),
    .s   (s_w),
    .co  (co_w)
  );

  always_comb begin
    a_d    = a_q >> 1;
    b_d    = b_q >> 1;
    c_d    = co_w;
    cnt_d  = cnt_q + CW'(1);
    res_d  = {s_w, res_q[WIDTH-1:1]};
    accept = start && (state_q == IDLE || state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        c_q     <= sub;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        state_q <= RUN;
      end else if (state_q == RUN) begin
        a_q   <= a_d;
        b_q   <= b_d;
        c_q   <= c_d;
        cnt_q <= cnt_d;
        res_q <= res_d;
        if (cnt_q == LAST) begin
          // c_q is still the carry into the MSB here, co_w the carry out of it.
          sum_q   <= res_d;
          cout_q  <= co_w;
          ovf_q   <= c_q ^ co_w;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8) using a result scoreboard.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   asserts = 0;
  int   fails = 0;

  serial_addsub #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic s);
    exp_t       e;
    logic [8:0] full;
    full   = {1'b0, x} + (s ? {1'b0, ~y} : {1'b0, y}) + {8'd0, s};
    e.sum  = full[7:0];
    e.cout = full[8];
    if (s) e.ovf = (x[7] != y[7]) && (full[7] != x[7]);
    else   e.ovf = (x[7] == y[7]) && (full[7] != x[7]);
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one cycle; returns in the first cycle after the start cycle.
  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic s, input bit push);
    a = x; b = y; sub = s; start = 1'b1;
    if (push) sb.push_back(model(x, y, s));
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int bcnt, output bit both, output bit tmo);
    lat = lat0; bcnt = 0; both = 1'b0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      cyc();
      lat++;
    end
    if (busy && done) both = 1'b1;
    tmo = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    asserts++;
    if ({busy, done, sum, cout, ovf} !== 12'h000) begin
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0", busy, done, sum, cout, ovf);
      fails++;
    end
    rst_n = 1'b1;
    cyc();
    asserts++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
      fails++;
    end
  endtask

  task automatic test_op(input string name, input logic [7:0] x, input logic [7:0] y, input logic s);
    int   lat, bcnt;
    bit   both, tmo;
    exp_t e;
    start_op(x, y, s, 1'b1);
    wait_done(1, lat, bcnt, both, tmo);
    e = sb.pop_front();
    asserts++;
    if (tmo) begin
      $display("FAIL %s_timeout: done never seen, waited %0d cycles", name, lat);
      fails++;
    end
    asserts++;
    if (lat !== 9) begin
      $display("FAIL %s_latency: got %0d, want 9", name, lat);
      fails++;
    end
    asserts++;
    if (bcnt !== 8 || both) begin
      $display("FAIL %s_busy: got %0d busy cycles overlap=%b, want 8 overlap=0", name, bcnt, both);
      fails++;
    end
    asserts++;
    if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
      $display("FAIL %s_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, e.sum, e.cout, e.ovf);
      fails++;
    end
    cyc();
    asserts++;
    if (done !== 1'b0 || sum !== e.sum) begin
      $display("FAIL %s_hold: got done=%b sum=%h, want done=0 sum=%h", name, done, sum, e.sum);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    int   lat, bcnt;
    bit   both, tmo;
    exp_t e;
    start_op(8'h12, 8'h34, 1'b0, 1'b1);
    cyc(); cyc();
    // RUN cycle 3: this request must be ignored.
    start_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done(4, lat, bcnt, both, tmo);
    e = sb.pop_front();
    asserts++;
    if (tmo || lat !== 9) begin
      $display("FAIL b2b_first_latency: got %0d timeout=%b, want 9", lat, tmo);
      fails++;
    end
    asserts++;
    if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
      $display("FAIL b2b_first_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
               sum, cout, ovf, e.sum, e.cout, e.ovf);
      fails++;
    end
    start_op(8'h01, 8'h02, 1'b0, 1'b1);
    wait_done(1, lat, bcnt, both, tmo);
    e = sb.pop_front();
    asserts++;
    if (tmo || lat !== 9 || bcnt !== 8) begin
      $display("FAIL b2b_second_timing: got lat=%0d busy=%0d timeout=%b, want 9 8", lat, bcnt, tmo);
      fails++;
    end
    asserts++;
    if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
      $display("FAIL b2b_second_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
               sum, cout, ovf, e.sum, e.cout, e.ovf);
      fails++;
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    bit seen;
    start_op(8'h77, 8'h11, 1'b0, 1'b0);
    cyc(); cyc(); cyc();
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({busy, done, sum, cout, ovf} !== 12'h000) begin
      $display("FAIL midreset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0", busy, done, sum, cout, ovf);
      fails++;
    end
    seen = 1'b0;
    repeat (3) begin
      cyc();
      if (done) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (8) begin
      cyc();
      if (done || busy) seen = 1'b1;
    end
    asserts++;
    if (seen) begin
      $display("FAIL midreset_no_done: got activity after abort, want none");
      fails++;
    end
    test_op("after_reset", 8'h22, 8'h11, 1'b0);
  endtask

  initial begin
    test_reset();
    test_op("add_ovf", 8'h5A, 8'h33, 1'b0);
    test_op("add_wrap", 8'hFF, 8'h01, 1'b0);
    test_op("sub_borrow", 8'h10, 8'h20, 1'b1);
    test_op("sub_ovf", 8'h80, 8'h01, 1'b1);
    for (int i = 0; i < 4; i++)
      test_op("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor built around a single one-bit full-adder cell reused over WIDTH clock cycles. A single `start` pulse loads two WIDTH-bit operands and an add/sub mode. The result, carry-out and signed overflow are returned with a one-cycle `done` pulse. It is the multi-bit, sequential successor to the combinational one-bit full adder, for datapaths where area matters more than latency.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low; one clock domain only.
- `start`  in  1  request a new operation; sampled in IDLE or DONE only.
- `sub`  in  1  mode, sampled with `start`: 0 selects a+b, 1 selects a−b.
- `a`  in  WIDTH  operand A, sampled with `start`.
- `b`  in  WIDTH  operand B, sampled with `start`.
- `busy`  out  1  high while bits are being processed (RUN state).
- `done`  out  1  one-cycle pulse: the result outputs are valid and newly updated.
- `sum`  out  WIDTH  result, held until the next completion.
- `cout`  out  1  carry out of the MSB; for subtraction, 1 means no borrow.
- `ovf`  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- **States:** IDLE, RUN, DONE.
- **Start accepted (IDLE or DONE with `start`=1):**
  - A register ← `a`.
  - B register ← `b` when `sub`=0, ~`b` when `sub`=1.
  - Carry register ← `sub`.
  - Bit counter ← 0.
  - Next state RUN.
- **RUN, every cycle:**
  - The cell adds A[0], B[0] and the carry.
  - The sum bit shifts into the MSB of the result shift register.
  - A and B shift right by one.
  - The carry register takes the cell carry-out.
  - The counter increments.
- **Last RUN cycle (counter = WIDTH−1):**
  - The carry into the MSB (carry register before the update) is captured for `ovf`.
  - On the same edge, `sum`, `cout` and `ovf` load from the final values.
  - Next state DONE.
- **DONE:**
  - `done`=1 for exactly this cycle.
  - With `start`=1, go to RUN (back-to-back operation); otherwise go to IDLE.
- **`start` in RUN:** ignored. No queuing, and operands and mode are unaffected.
- **`sum`/`cout`/`ovf`:** change only on the completion edge. Intermediate bits are never visible on these outputs.
- **Widths:**
  - Counter is $clog2(WIDTH) bits.
  - Arithmetic is modulo 2^WIDTH.
  - The carry chain is 1 bit wide, per bit.

## Timing
- **Reset values:** `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0. All internal registers are 0 and the state is IDLE.
- **Latency:**
  - `start` high in cycle c (accepted) gives `busy`=1 in cycles c+1 … c+WIDTH.
  - `done`=1 in cycle c+WIDTH+1, with `sum`/`cout`/`ovf` valid from that cycle.
- **Throughput:** one result per WIDTH+1 cycles with `start` held or re-asserted in DONE.
- **`busy` and `done`:** never high together.
- **Reset mid-operation:** asynchronous assertion immediately returns all outputs to their reset values. No `done` pulse for the aborted operation. The first `start` after `rst_n` deasserts behaves normally.
- **All outputs are registered;** there is no combinational path from inputs to outputs.

## Structure
- **Package `serial_addsub_pkg`:**
  - State enum: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Counter-width helper function.
- **Sub-module `fa_cell`:** combinational 1-bit full adder with ports a, b, cin, s, co. Instantiated exactly once.
- **Top level:** the FSM, operand/result shift registers, carry register and output registers.

## Test plan
All scenarios use WIDTH=8.
- **Add with signed overflow:** `a`=8'h5A, `b`=8'h33, `sub`=0 → `sum`=8'h8D, `cout`=0, `ovf`=1. `done` exactly 9 cycles after the `start` cycle; `busy` high for 8 cycles.
- **Add wrap-around:** `a`=8'hFF, `b`=8'h01, `sub`=0 → `sum`=8'h00, `cout`=1, `ovf`=0.
- **Subtract with borrow:** `a`=8'h10, `b`=8'h20, `sub`=1 → `sum`=8'hF0, `cout`=0, `ovf`=0.
- **Subtract with overflow:** `a`=8'h80, `b`=8'h01, `sub`=1 → `sum`=8'h7F, `cout`=1, `ovf`=1.
- **`start` during RUN, then back-to-back:**
  - Pulse `start` with new operands at RUN cycle 3 → ignored, and the first result is unchanged.
  - Then assert `start` in the DONE cycle with 8'h01+8'h02 → second `done` 9 cycles later with `sum`=8'h03.
- **Reset mid-operation:**
  - Assert `rst_n`=0 during RUN cycle 4 → all outputs 0 at once, no `done` pulse.
  - After release, 8'h22+8'h11 → `sum`=8'h33, `cout`=0, `ovf`=0, `done` after 9 cycles.
